// File: rtl/add_pkg.sv
// Shared constants and FSM state type for the add_1p downstream frame accumulator.
package add_pkg;

  localparam int ADD_W     = 15;
  localparam int ADD_ACC_W = 20;
  localparam int ADD_CNT_W = 5;

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

endpackage

// File: rtl/add_accum_outreg.sv
// Valid/ready holding register for a finished frame: load, hold until taken, clear on handshake.
module add_accum_outreg #(
  parameter int ACC_W = 20,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [ACC_W-1:0]   d_sum,
  input  logic [CNT_W:0]     d_count,
  input  logic               d_ovf,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CNT_W:0]     out_count,
  output logic               out_ovf
);

  // A load in the handshake cycle replaces the taken result and keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_sum   <= d_sum;
      out_count <= d_count;
      out_ovf   <= d_ovf;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/add_1p_accum.sv
// Frame accumulator for add_1p sums with programmable frame length, flush and valid/ready output.
// Define ACC_SAT_EN to saturate the accumulator at all-ones on overflow instead of wrapping.
module add_1p_accum
  import add_pkg::*;
#(
  parameter int W     = ADD_W,
  parameter int ACC_W = ADD_ACC_W,
  parameter int CNT_W = ADD_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic [CNT_W-1:0]   frame_len,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CNT_W:0]     out_count,
  output logic               out_ovf
);

  localparam logic [CNT_W:0] FULL_LEN = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] ONE_CNT  = {{CNT_W{1'b0}}, 1'b1};

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W:0]   cnt_q;
  logic [CNT_W:0]   len_q;
  logic             ovf_q;

  logic             is_idle;
  logic             blocked;
  logic             would_last;
  logic             closing;
  logic             accept;
  logic             do_close;
  logic [CNT_W:0]   len_eff;
  logic [CNT_W:0]   cur_len;
  logic [CNT_W:0]   base_cnt;
  logic [CNT_W:0]   cnt_nx;
  logic [ACC_W-1:0] base_acc;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nx;
  logic             ovf_nx;

  always_comb begin
    is_idle    = (state_q == IDLE);
    blocked    = out_valid && !out_ready;
    len_eff    = (frame_len == '0) ? FULL_LEN : {1'b0, frame_len};
    // In IDLE the incoming sample opens the frame, so the live frame_len decides its length.
    cur_len    = is_idle ? len_eff : len_q;
    base_cnt   = is_idle ? '0 : cnt_q;
    base_acc   = is_idle ? '0 : acc_q;
    would_last = ((base_cnt + ONE_CNT) == cur_len);
    closing    = would_last || flush;
    in_ready   = !(blocked && closing);
    accept     = in_valid && in_ready;

    sum    = {1'b0, base_acc} + (accept ? (ACC_W+1)'(in_data) : '0);
    ovf_nx = (ovf_q && !is_idle) || sum[ACC_W];
`ifdef ACC_SAT_EN
    acc_nx = ovf_nx ? '1 : sum[ACC_W-1:0];
`else
    acc_nx = sum[ACC_W-1:0];
`endif
    cnt_nx = base_cnt + (accept ? ONE_CNT : '0);

    // A flush without a sample closes only an open frame, and only once the output slot is free.
    do_close = (accept && closing) || (!is_idle && flush && !accept && !blocked);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (do_close) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      state_q <= ACC;
      acc_q   <= acc_nx;
      cnt_q   <= cnt_nx;
      ovf_q   <= ovf_nx;
      if (is_idle) len_q <= len_eff;
    end
  end

  add_accum_outreg #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (do_close),
    .d_sum     (acc_nx),
    .d_count   (cnt_nx),
    .d_ovf     (ovf_nx),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

endmodule

// File: tb/tb_add_1p_accum.sv
// Scoreboard bench for add_1p_accum: directed frames push expected results, a monitor pops on handshake.
module tb_add_1p_accum;

  localparam int W     = 15;
  localparam int ACC_W = 16;
  localparam int CNT_W = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_data;
  logic [CNT_W-1:0]   frame_len;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic [CNT_W:0]     out_count;
  logic               out_ovf;

  typedef struct {
    logic [ACC_W-1:0] s;
    logic [CNT_W:0]   c;
    logic             o;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  add_1p_accum #(
    .W     (W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .frame_len (frame_len),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic expect_frame(input int s, input int c, input logic o);
    exp_t e;
    e.s = ACC_W'(s);
    e.c = (CNT_W+1)'(c);
    e.o = o;
    q.push_back(e);
  endtask

  // Called just after a posedge; returns just after the edge that accepted the sample.
  task automatic send(input int d, input logic f);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = W'(d);
    flush    = f;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stuck 0 for sample %0d", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL sb_unexpected: got sum=%0d count=%0d ovf=%0d with no result expected",
                 out_sum, out_count, out_ovf);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_sum === e.s && out_count === e.c && out_ovf === e.o) n_pass++;
        else $display("FAIL sb_frame: got sum=%0d count=%0d ovf=%0d expected sum=%0d count=%0d ovf=%0d",
                      out_sum, out_count, out_ovf, e.s, e.c, e.o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    frame_len = 5'd4;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sum",   32'(out_sum),   0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_ovf",   32'(out_ovf),   0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Basic frame of four
    frame_len = 5'd4;
    expect_frame(100, 4, 1'b0);
    send(10, 0); send(20, 0); send(30, 0); send(40, 0);
    chk("t1_latency", 32'(out_valid), 1);
    chk("t1_sum",     32'(out_sum),   100);
    @(posedge clk); #1;
    chk("t1_one_cycle", 32'(out_valid), 0);

    // Back-pressure with one-frame overlap
    frame_len = 5'd2;
    out_ready = 1'b0;
    expect_frame(11, 2, 1'b0);
    send(5, 0); send(6, 0);
    chk("t2_held_valid", 32'(out_valid), 1);
    send(7, 0);
    in_valid = 1'b1;
    in_data  = 15'd8;
    @(negedge clk);
    chk("t2_blocked", 32'(in_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_blocked2", 32'(in_ready), 0);
    chk("t2_hold_sum", 32'(out_sum), 11);
    @(posedge clk); #1;
    expect_frame(15, 2, 1'b0);
    out_ready = 1'b1;
    send(8, 0);
    chk("t2_reload_valid", 32'(out_valid), 1);
    chk("t2_reload_sum",   32'(out_sum),   15);
    @(posedge clk); #1;

    // Flush closes early; flush in IDLE is ignored
    frame_len = 5'd8;
    expect_frame(21, 3, 1'b0);
    send(5, 0); send(7, 0); send(9, 1);
    @(posedge clk); #1;
    flush = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_idle_flush", 32'(out_valid), 0);
    end
    @(posedge clk); #1;
    flush = 1'b0;

    // Overflow
    frame_len = 5'd3;
`ifdef ACC_SAT_EN
    expect_frame(65535, 3, 1'b1);
`else
    expect_frame(32765, 3, 1'b1);
`endif
    send(32767, 0); send(32767, 0); send(32767, 0);
    @(posedge clk); #1;

    // frame_len change mid-frame is ignored
    frame_len = 5'd4;
    expect_frame(10, 4, 1'b0);
    send(1, 0);
    frame_len = 5'd2;
    send(2, 0); send(3, 0); send(4, 0);
    @(posedge clk); #1;

    // Reset mid-frame discards the partial frame
    frame_len = 5'd4;
    send(1, 0); send(2, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_sum",   32'(out_sum),   0);
    chk("t5_rst_count", 32'(out_count), 0);
    chk("t5_rst_ovf",   32'(out_ovf),   0);
    rst = 1'b0;
    expect_frame(18, 4, 1'b0);
    send(3, 0); send(4, 0); send(5, 0); send(6, 0);
    @(posedge clk); #1;

    // frame_len 0 means 32 samples; frame_len 1 makes every sample a frame
    frame_len = 5'd0;
    expect_frame(528, 32, 1'b0);
    for (int i = 1; i <= 32; i++) send(i, 0);
    @(posedge clk); #1;
    frame_len = 5'd1;
    for (int i = 1; i <= 3; i++) begin
      expect_frame(100 * i, 1, 1'b0);
      send(100 * i, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
